// File: rtl/game_board_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_board_arbiter_pkg
// Description : Shared types and constants for the game board RAM arbiter:
//               FSM state encoding, requester indices and the idle select code.
// Revision    : 1.0 - initial release
// ============================================================================
package game_board_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Requester indices, which double as read-address mux select codes
  localparam logic [2:0] G1      = 3'd0;
  localparam logic [2:0] G2      = 3'd1;
  localparam logic [2:0] G3      = 3'd2;
  localparam logic [2:0] G4      = 3'd3;
  localparam logic [2:0] PAC     = 3'd4;
  localparam logic [2:0] PAINT   = 3'd5;
  localparam logic [2:0] DISPLAY = 3'd6;

  // Select code driven while no access is in flight
  localparam logic [2:0] SEL_IDLE = 3'd7;

endpackage
`default_nettype wire

// File: rtl/game_board_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : game_board_arbiter_if
// Description : Request / grant / read-return bundle between the board RAM
//               arbiter (master) and its requesters plus RAM (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface game_board_arbiter_if #(
  parameter int NREQ   = 7,
  parameter int DATA_W = 4
);
  logic [NREQ-1:0]   req;
  logic [DATA_W-1:0] ram_rdata;
  logic [2:0]        select;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rvalid;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    input  req, ram_rdata,
    output select, gnt, rvalid, rdata, busy
  );

  modport slave (
    output req, ram_rdata,
    input  select, gnt, rvalid, rdata, busy
  );
endinterface
`default_nettype wire

// File: rtl/game_board_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin search. Returns the first set
//               request at or after the pointer, wrapping modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
  parameter int NREQ = 7
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [2:0]      i_ptr,
  output logic [2:0]      o_winner,
  output logic            o_any
);

  // Scan from the farthest offset back to the pointer so the nearest request is written last and wins
  always_comb begin
    logic [3:0] w_idx;
    w_idx    = 4'd0;
    o_winner = 3'd0;
    o_any    = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = {1'b0, i_ptr} + 4'(i);
      if (w_idx >= 4'(NREQ)) begin
        w_idx = w_idx - 4'(NREQ);
      end
      if (i_req[w_idx[2:0]]) begin
        o_winner = w_idx[2:0];
        o_any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/game_board_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : game_board_arbiter
// Description : Single-port board RAM read arbiter. IDLE -> ISSUE -> WAIT
//               (RAM_LAT cycles) -> DONE, round-robin between requesters.
//               Option macro GB_ARB_DISPLAY_PRIORITY_EN: display (requester 6)
//               pre-empts arbitration and leaves the round-robin pointer alone.
// Revision    : 1.0 - initial release
// ============================================================================
module game_board_arbiter
  import game_board_arbiter_pkg::*;
#(
  parameter int NREQ    = 7,
  parameter int DATA_W  = 4,
  parameter int RAM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  game_board_arbiter_if.master bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_winner;
  logic [2:0]        r_ptr;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_rdata;

  logic [NREQ-1:0]   w_rr_req;
  logic [2:0]        w_pick;
  logic              w_pick_any;
  logic [2:0]        w_win;
  logic              w_any;
  logic [2:0]        w_ptr_nxt;
  logic [NREQ-1:0]   w_onehot;
  logic [2:0]        w_select;
  logic [NREQ-1:0]   w_gnt;
  logic [NREQ-1:0]   w_rvalid;
  logic              w_busy;

  // Requests visible to the round-robin search; display is removed when it has its own priority path
  always_comb begin
    w_rr_req = bus.req;
`ifdef GB_ARB_DISPLAY_PRIORITY_EN
    w_rr_req[DISPLAY] = 1'b0;
`endif
  end

  rr_picker #(
    .NREQ (NREQ)
  ) u_rr_picker (
    .i_req    (w_rr_req),
    .i_ptr    (r_ptr),
    .o_winner (w_pick),
    .o_any    (w_pick_any)
  );

`ifdef GB_ARB_DISPLAY_PRIORITY_EN
  assign w_win     = bus.req[DISPLAY] ? DISPLAY : w_pick;
  assign w_any     = bus.req[DISPLAY] | w_pick_any;
  // A display access must not disturb the fairness order of the others
  assign w_ptr_nxt = (r_winner == DISPLAY) ? r_ptr :
                     (r_winner == 3'(NREQ - 1)) ? 3'd0 : r_winner + 3'd1;
`else
  assign w_win     = w_pick;
  assign w_any     = w_pick_any;
  assign w_ptr_nxt = (r_winner == 3'(NREQ - 1)) ? 3'd0 : r_winner + 3'd1;
`endif

  assign w_onehot = {{(NREQ - 1){1'b0}}, 1'b1} << r_winner;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode; select only moves when the state changes
  always_comb begin
    w_state_nxt = r_state;
    w_select    = SEL_IDLE;
    w_gnt       = '0;
    w_rvalid    = '0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_any) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_select    = r_winner;
        w_gnt       = w_onehot;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_select = r_winner;
        if (r_cnt == 2'd0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_select    = r_winner;
        w_rvalid    = w_onehot;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Winner latch, wait-cycle counter, read data capture and pointer advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_winner <= 3'd0;
      r_ptr    <= 3'd0;
      r_cnt    <= 2'd0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_winner <= w_win;
          end
        end
        ST_ISSUE: begin
          r_cnt <= 2'(RAM_LAT - 1);
        end
        ST_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_rdata <= bus.ram_rdata;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_DONE: begin
          r_ptr <= w_ptr_nxt;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.select = w_select;
  assign bus.gnt    = w_gnt;
  assign bus.rvalid = w_rvalid;
  assign bus.rdata  = r_rdata;
  assign bus.busy   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_game_board_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_board_arbiter
// Description : Directed self-checking bench for game_board_arbiter, one
//               instance with RAM_LAT=1 and one with RAM_LAT=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_board_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  game_board_arbiter_if #(.NREQ(7), .DATA_W(4)) bus1 ();
  game_board_arbiter_if #(.NREQ(7), .DATA_W(4)) bus3 ();

  game_board_arbiter #(.NREQ(7), .DATA_W(4), .RAM_LAT(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  game_board_arbiter #(.NREQ(7), .DATA_W(4), .RAM_LAT(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Advance to the next grant on bus1 (bounded) and check it is the expected requester
  task automatic wait_gnt(input string tag, input int exp);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus1.gnt == 7'h00 && n < 20);
    check(tag, 32'(bus1.gnt), 32'(7'b1 << exp));
    check({tag, "_sel"}, 32'(bus1.select), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_rr;
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b0;
    bus1.req       = '0;
    bus1.ram_rdata = '0;
    bus3.req       = '0;
    bus3.ram_rdata = '0;

    // ---- reset state and idle with no requests
    do_reset();
    check("rst_rdata", 32'(bus1.rdata), 32'h0);
    for (int i = 0; i < 10; i++) begin
      check("idle_sel",    32'(bus1.select), 32'h7);
      check("idle_busy",   32'(bus1.busy),   32'h0);
      check("idle_gnt",    32'(bus1.gnt),    32'h0);
      check("idle_rvalid", 32'(bus1.rvalid), 32'h0);
      tick();
    end

    // ---- single PacMan access, RAM_LAT=1
    bus1.req       = 7'h10;
    bus1.ram_rdata = 4'hA;
    tick();
    check("pac_gnt",     32'(bus1.gnt),    32'h10);
    check("pac_sel_iss", 32'(bus1.select), 32'h4);
    check("pac_busy",    32'(bus1.busy),   32'h1);
    tick();
    check("pac_sel_wait",   32'(bus1.select), 32'h4);
    check("pac_gnt_wait",   32'(bus1.gnt),    32'h0);
    check("pac_rv_wait",    32'(bus1.rvalid), 32'h0);
    tick();
    check("pac_rvalid", 32'(bus1.rvalid), 32'h10);
    check("pac_rdata",  32'(bus1.rdata),  32'hA);
    tick();
    bus1.req = 7'h00;
    check("pac_back_idle_sel",  32'(bus1.select), 32'h7);
    check("pac_back_idle_busy", 32'(bus1.busy),   32'h0);
    tick();
    check("pac_no_regrant", 32'(bus1.gnt), 32'h0);

    // ---- all requesters held: round-robin order from pointer 0
    do_reset();
    bus1.req = 7'h7F;
    for (int i = 0; i < 8; i++) begin
`ifdef GB_ARB_DISPLAY_PRIORITY_EN
      exp_rr = 6;
`else
      exp_rr = i % 7;
`endif
      wait_gnt($sformatf("rr_all_%0d", i), exp_rr);
    end
    bus1.req = 7'h00;

    // ---- display and ghost 1 held
    do_reset();
    bus1.req = 7'h41;
    for (int i = 0; i < 3; i++) begin
`ifdef GB_ARB_DISPLAY_PRIORITY_EN
      exp_rr = 6;
`else
      exp_rr = (i == 1) ? 6 : 0;
`endif
      wait_gnt($sformatf("disp_%0d", i), exp_rr);
    end
    bus1.req = 7'h01;
    wait_gnt("disp_drop", 0);
    bus1.req = 7'h00;

    // ---- requester 2 drops req during WAIT; access still completes
    do_reset();
    bus1.req       = 7'h04;
    bus1.ram_rdata = 4'h5;
    tick();
    check("drop_gnt", 32'(bus1.gnt), 32'h04);
    tick();
    bus1.req = 7'h00;
    tick();
    check("drop_rvalid", 32'(bus1.rvalid), 32'h04);
    check("drop_rdata",  32'(bus1.rdata),  32'h5);
    tick();
    tick();
    check("drop_no_regrant", 32'(bus1.gnt),  32'h0);
    check("drop_idle_busy",  32'(bus1.busy), 32'h0);

    // ---- reset during WAIT abandons the access
    bus1.req = 7'h04;
    tick();
    check("rstw_gnt", 32'(bus1.gnt), 32'h04);
    tick();
    check("rstw_in_wait", 32'(bus1.busy), 32'h1);
    rst      = 1'b1;
    bus1.req = 7'h00;
    tick();
    check("rstw_sel",    32'(bus1.select), 32'h7);
    check("rstw_rvalid", 32'(bus1.rvalid), 32'h0);
    check("rstw_busy",   32'(bus1.busy),   32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstw_no_rvalid", 32'(bus1.rvalid), 32'h0);
      check("rstw_no_gnt",    32'(bus1.gnt),    32'h0);
    end

    // ---- RAM_LAT=3: three WAIT cycles, data sampled in the last one
    do_reset();
    bus3.req       = 7'h01;
    bus3.ram_rdata = 4'h1;
    tick();
    check("l3_gnt", 32'(bus3.gnt),    32'h01);
    check("l3_sel", 32'(bus3.select), 32'h0);
    bus3.ram_rdata = 4'h2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("l3_wait%0d_sel", i),  32'(bus3.select), 32'h0);
      check($sformatf("l3_wait%0d_rv", i),   32'(bus3.rvalid), 32'h0);
      check($sformatf("l3_wait%0d_busy", i), 32'(bus3.busy),   32'h1);
      bus3.ram_rdata = 4'(i + 3);
    end
    tick();
    check("l3_rvalid", 32'(bus3.rvalid), 32'h01);
    check("l3_rdata",  32'(bus3.rdata),  32'h5);
    tick();
    bus3.req = 7'h00;
    check("l3_idle_sel", 32'(bus3.select), 32'h7);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_board_arbiter.md
GAME_BOARD_ARBITER -- requirements
Module: game_board_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 7, number of requesters: 0-3 = ghosts g1-g4, 4 = PacMan, 5 = paint, 6 = display.
REQ-002 SHALL have parameter DATA_W, default 4, width of the board RAM read data (tile code).
REQ-003 SHALL have parameter RAM_LAT, default 1, board RAM read latency in cycles, legal range 1-3.
REQ-004 Clk  input  1  the single clock; all logic is rising-edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 req  input  NREQ  per-requester read request, level-held until serviced.
REQ-007 ram_rdata  input  DATA_W  board RAM read data.
REQ-008 select  output  3  read-address mux select; code equals requester index, 3'd7 = idle.
REQ-009 gnt  output  NREQ  one-hot, high for one cycle in ISSUE.
REQ-010 rvalid  output  NREQ  one-hot data-return strobe, one cycle.
REQ-011 rdata  output  DATA_W  registered read data, valid while rvalid != 0.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, ISSUE, WAIT and DONE.
REQ-014 IDLE: select=7; if any req bit is set, register winner w and go to ISSUE the next cycle; otherwise stay.
REQ-015 ISSUE: select=w, gnt[w]=1 for exactly one cycle; go to WAIT.
REQ-016 WAIT: select held at w for RAM_LAT cycles (down-counter); then go to DONE.
REQ-017 DONE: rvalid[w]=1, rdata=ram_rdata sampled at the WAIT->DONE edge; pointer := (w+1) mod NREQ (wrap 6->0); go to IDLE.
REQ-018 Access latency SHALL be req-seen-in-IDLE to rvalid = RAM_LAT+2 cycles; peak throughput is one access per RAM_LAT+3 cycles.
REQ-019 Winner selection SHALL be round-robin, starting the search at pointer.
REQ-020 A requester SHALL drop req in the cycle after its rvalid; a held req re-enters arbitration normally.
REQ-021 Deassertion of req[w] during ISSUE/WAIT/DONE SHALL NOT abort the access; rvalid still pulses.
REQ-022 New req edges during an access SHALL be ignored until IDLE; nothing is queued internally.
REQ-023 select SHALL change only on state transitions, never in the middle of WAIT.
REQ-024 At most one bit of gnt and one bit of rvalid SHALL ever be set.

Reset
REQ-025 Reset SHALL force IDLE, pointer=0, select=7, gnt=0, rvalid=0, rdata=0, busy=0 on the next edge.
REQ-026 Reset asserted mid-access SHALL abandon it with no rvalid; the access is not replayed.

Configuration
REQ-027 Macro GB_ARB_DISPLAY_PRIORITY_EN defined: requester 6 (display) SHALL win over all others whenever set in IDLE; round-robin applies to 0-5 only, and the pointer is unchanged after a display access.
REQ-028 Macro GB_ARB_DISPLAY_PRIORITY_EN undefined: all NREQ requesters SHALL be plain round-robin.

Structure
REQ-029 Shared package SHALL hold the state enum, requester index constants (G1..G4, PAC, PAINT, DISPLAY), and SEL_IDLE=3'd7.
REQ-030 Sub-module rr_picker SHALL hold the combinational round-robin search (req, pointer -> winner, any); the FSM stays in the top module.

Verification
REQ-031 Reset, req=7'h00 for 10 cycles -> select=7, busy=0, gnt=rvalid=0 throughout.
REQ-032 RAM_LAT=1, req=7'h10 (PacMan), ram_rdata=4'hA -> gnt[4] 1 cycle after req, rvalid[4] with rdata=A 3 cycles after req, select=4 in ISSUE/WAIT.
REQ-033 Priority macro off, req=7'h7F held -> grant order 0,1,...,6,0; no requester serviced twice before all others.
REQ-034 Priority macro on, req=7'h41 held -> grant order 6,6,6... with 0 starved while 6 is held; drop 6 -> 0 granted next IDLE.
REQ-035 req[2] dropped in WAIT -> rvalid[2] still pulses; Reset in WAIT -> no rvalid, select=7 the next cycle.
REQ-036 RAM_LAT=3 -> WAIT lasts 3 cycles, select stable, rdata equals ram_rdata presented 3 cycles after ISSUE.
